// File: rtl/app_tot_tagger.sv
// Comparator pulse qualifier: sync, TOT shaping, metadata tag, memory reset sequencing.
// Optional feature: define APP_TAGGER_GLITCH_FILTER_EN for two-sample rise/fall decisions.
module app_tot_tagger #(
    parameter int SYNC_STAGES = 2,
    parameter int RST_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vcomp,
    input  logic        timeout_enable,
    input  logic [15:0] timeout_threshold,
    output logic        TOT,
    output logic [7:0]  metadata,
    output logic        resetb_full,
    output logic [15:0] tot_width,
    output logic        width_valid,
    output logic        event_missed
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_RESET,
        S_ARM,
        S_IDLE,
        S_HIGH
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sync;
    logic                   vs;
    logic                   vs_d;
    logic [RCW-1:0]         rst_cnt, rst_cnt_n;
    logic [15:0]            cnt, cnt_n;
    logic                   tot_n;
    logic [7:0]             meta_n;
    logic                   resetb_n;
    logic [15:0]            width_n;
    logic                   wv_n;
    logic                   miss_n;
    logic                   rise_ok;
    logic                   fall_ok;
    logic                   timeout;
    logic                   rst_last;

    assign vs = sync[SYNC_STAGES-1];

`ifdef APP_TAGGER_GLITCH_FILTER_EN
    assign rise_ok = vs & vs_d;
    assign fall_ok = ~vs & ~vs_d;
`else
    assign rise_ok = vs;
    assign fall_ok = ~vs;
`endif

    assign timeout = timeout_enable
                   && (timeout_threshold != 16'd0)
                   && (cnt == timeout_threshold);

    assign rst_last = (rst_cnt == RCW'(RST_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync         <= '0;
            vs_d         <= 1'b0;
            state        <= S_RESET;
            rst_cnt      <= '0;
            cnt          <= '0;
            TOT          <= 1'b0;
            metadata     <= '0;
            resetb_full  <= 1'b0;
            tot_width    <= '0;
            width_valid  <= 1'b0;
            event_missed <= 1'b0;
        end else begin
            sync         <= {sync[SYNC_STAGES-2:0], vcomp};
            vs_d         <= vs;
            state        <= state_n;
            rst_cnt      <= rst_cnt_n;
            cnt          <= cnt_n;
            TOT          <= tot_n;
            metadata     <= meta_n;
            resetb_full  <= resetb_n;
            tot_width    <= width_n;
            width_valid  <= wv_n;
            event_missed <= miss_n;
        end
    end

    always_comb begin
        state_n   = state;
        rst_cnt_n = rst_cnt;
        cnt_n     = cnt;
        tot_n     = TOT;
        meta_n    = metadata;
        resetb_n  = resetb_full;
        width_n   = tot_width;
        wv_n      = 1'b0;
        miss_n    = 1'b0;
        unique case (state)
            S_RESET: begin
                // rises here are dropped; ARM waits for them to end
                miss_n = vs & ~vs_d;
                if (rst_last) begin
                    state_n   = S_ARM;
                    rst_cnt_n = '0;
                    resetb_n  = 1'b1;
                end else begin
                    rst_cnt_n = rst_cnt + 1'b1;
                end
            end
            S_ARM: begin
                if (!vs) begin
                    state_n = S_IDLE;
                end
            end
            S_IDLE: begin
                if (rise_ok) begin
                    state_n = S_HIGH;
                    tot_n   = 1'b1;
                    meta_n  = {1'b0, metadata[6:0] + 7'd1};
                    cnt_n   = 16'd1;
                end
            end
            S_HIGH: begin
                if (timeout || fall_ok) begin
                    state_n     = S_RESET;
                    tot_n       = 1'b0;
                    width_n     = cnt;
                    wv_n        = 1'b1;
                    resetb_n    = 1'b0;
                    rst_cnt_n   = '0;
                    meta_n[7]   = timeout;
                end else if (cnt != 16'hFFFF) begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: begin
                state_n = S_RESET;
            end
        endcase
    end

endmodule
